spram_ctrl: RTL and testbench

Request front-end for `single_port_ram`, sitting directly upstream of it. It clears the RAM to a constant value after reset or on command. It then arbitrates a single valid/ready request stream (reads and writes) onto the RAM's one port. Read data returns on a buffered valid/ready response stream, so downstream back-pressure never loses data.

---
 rtl/spram_ctrl_if.sv | 31 +++
 rtl/spram_ctrl.sv | 121 ++++++++++++
 tb/tb_spram_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_ctrl_if.sv
// Request, response and RAM-port bundle between an upstream client, spram_ctrl and single_port_ram.
// Controller side uses 'slave'; the client/RAM side uses 'master'.
interface spram_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/spram_ctrl.sv
// Front-end for single_port_ram: clear sweep after reset/clear, then one request per cycle onto the
// RAM port, with read data returned through a 4-entry credit-guarded response FIFO.
module spram_ctrl #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    output logic        init_busy_o,
    spram_ctrl_if.slave bus
);
    localparam int                    FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [2:0]            count_q, count_d;

    logic                  credit_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // A read in flight already owns a FIFO slot, so it is counted against the credit.
    assign credit_ok = (count_q + {2'b00, inflight_q}) < 3'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:  if (clear_i)            state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        init_busy_o   = 1'b0;
        bus.req_ready = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = bus.req_addr;
        bus.ram_din   = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                init_busy_o  = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_din  = INIT_VALUE;
            end
            ST_RUN: begin
                bus.req_ready = credit_ok;
                bus.ram_we    = bus.req_valid & credit_ok & bus.req_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        accept     = bus.req_valid & bus.req_ready;
        push       = inflight_q;
        pop        = bus.rsp_valid & bus.rsp_ready;
        inflight_d = accept & ~bus.req_we;
        cnt_d      = '0;
        if (state_q == ST_INIT && cnt_q != LAST_ADDR) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
        wptr_d  = wptr_q + 2'(push);
        rptr_d  = rptr_q + 2'(pop);
        count_d = count_q + 3'(push) - 3'(pop);
    end

    // RAM dout holds through sweep writes, so an in-flight read is still captured after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wptr_q] <= bus.ram_dout;
            end
        end
    end

    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_data  = fifo_q[rptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == 3'(FIFO_DEPTH)));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_data)));
endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl: behavioural single_port_ram, request driver, and a scoreboard of read data
// predicted from a reference memory at request acceptance.
module tb_spram_ctrl;
    localparam int          AW     = 4;
    localparam int          DW     = 8;
    localparam logic [7:0]  INIT_V = 8'h00;

    logic clk;
    logic rst_n;
    logic clear;
    logic init_busy;

    spram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_V)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .init_busy_o(init_busy),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single_port_ram: registered read, dout held during writes
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    int nchk = 0;
    int nerr = 0;
    int gaps = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] exp_q [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held       = '0;

    // Monitor samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 2**AW; i++) model_mem[i] = INIT_V;
            stall_prev = 1'b0;
        end else begin
            if (bus.rsp_valid && stall_prev) check("rsp_hold", bus.rsp_data, held);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else                   check("rsp_data", bus.rsp_data, exp_q.pop_front());
            end
            stall_prev = bus.rsp_valid && !bus.rsp_ready;
            held       = bus.rsp_data;
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) model_mem[bus.req_addr] = bus.req_wdata;
                else            exp_q.push_back(model_mem[bus.req_addr]);
            end
            if (clear) begin
                for (int i = 0; i < 2**AW; i++) model_mem[i] = INIT_V;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int c = 0; c < 200; c++) begin
            #4;
            if (bus.req_ready) ok = 1'b1;
            else               gaps++;
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) check("req_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        #4;
        check("rsp_idle", bus.rsp_valid, 0);
        @(negedge clk);
    endtask

    // Counts sampled cycles with init_busy high; optionally pulses clear at iteration clr_at.
    task automatic count_busy(input int clr_at, output int n, output logic rdy,
                              output logic [AW-1:0] first_addr, output logic first_we);
        logic busy;
        n = 0;
        rdy = 1'b0;
        first_addr = '1;
        first_we = 1'b0;
        for (int c = 0; c < 100; c++) begin
            clear = (c == clr_at);
            #4;
            busy = init_busy;
            if (c == 0) begin
                first_addr = bus.ram_addr;
                first_we   = bus.ram_we;
            end
            if (!busy) rdy = bus.req_ready;
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        clear = 1'b0;
    endtask

    int            n_busy;
    logic          rdy;
    logic [AW-1:0] faddr;
    logic          fwe;
    int            nxt;
    int            acc;
    bit            pend;

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("rst_init_busy", init_busy, 1);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(-1, n_busy, rdy, faddr, fwe);
        check("sweep_cycles", n_busy, 16);
        check("ready_after_sweep", rdy, 1);
        check("sweep_first_addr", faddr, 0);
        check("sweep_first_we", fwe, 1);

        // read latency: two cycles from acceptance to rsp_valid
        do_req(1'b0, 4'd0, 8'h00);
        #4;
        check("lat_cycle1", bus.rsp_valid, 0);
        @(negedge clk);
        #4;
        check("lat_cycle2", bus.rsp_valid, 1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) do_req(1'b0, 4'(i), 8'h00);
        drain();

        // write then read same address back-to-back
        do_req(1'b1, 4'd3, 8'hA5);
        do_req(1'b0, 4'd3, 8'h00);
        #4;
        @(negedge clk);
        #4;
        check("wr_rd_valid", bus.rsp_valid, 1);
        check("wr_rd_data", bus.rsp_data, 8'hA5);
        @(negedge clk);
        drain();

        // streaming writes then reads with no ready gaps
        gaps = 0;
        for (int i = 0; i < 16; i++) do_req(1'b1, 4'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 16; i++) do_req(1'b0, 4'(i), 8'h00);
        check("stream_gaps", gaps, 0);
        drain();

        // back-pressure: 4 credits only
        for (int i = 1; i <= 6; i++) do_req(1'b1, 4'(i), 8'(i * 17));
        bus.rsp_ready = 1'b0;
        nxt = 1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus.req_valid = (nxt <= 6);
            bus.req_we    = 1'b0;
            bus.req_addr  = 4'(nxt);
            #4;
            if (bus.req_valid && bus.req_ready) begin nxt++; acc++; end
            @(negedge clk);
        end
        #4;
        check("bp_accepted", acc, 4);
        check("bp_ready_low", bus.req_ready, 0);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.req_valid = (nxt <= 6);
            bus.req_addr  = 4'(nxt);
            #4;
            if (bus.req_valid && bus.req_ready) begin nxt++; acc++; end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("bp_total", acc, 6);
        drain();

        // clear mid-traffic
        for (int i = 0; i < 16; i++) do_req(1'b1, 4'(i), 8'hFF);
        do_req(1'b0, 4'd2, 8'h00);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        count_busy(5, n_busy, rdy, faddr, fwe);
        check("clear_sweep_cycles", n_busy, 16);
        check("clear_ready_after", rdy, 1);
        for (int i = 0; i < 4; i++) do_req(1'b0, 4'(i), 8'h00);
        drain();

        // async reset with responses queued and sweep half done
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 4'd4, 8'h00);
        do_req(1'b0, 4'd5, 8'h00);
        do_req(1'b0, 4'd6, 8'h00);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        check("pre_rst_valid", bus.rsp_valid, 1);
        check("pre_rst_busy", init_busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", bus.rsp_valid, 0);
        check("async_rsp_data", bus.rsp_data, 0);
        check("async_busy", init_busy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        count_busy(-1, n_busy, rdy, faddr, fwe);
        check("rerun_sweep_cycles", n_busy, 16);
        check("rerun_first_addr", faddr, 0);
        check("rerun_queue_empty", bus.rsp_valid, 0);
        check("rerun_model_empty", exp_q.size(), 0);

        // randomized traffic with random back-pressure
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend          = 1'b1;
                bus.req_we    = ($urandom_range(0, 1) == 1);
                bus.req_addr  = 4'($urandom_range(0, 15));
                bus.req_wdata = 8'($urandom_range(0, 255));
            end
            bus.req_valid = pend;
            #4;
            if (pend && bus.req_ready) pend = 1'b0;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", nerr, nchk);
        $fatal(1, "watchdog");
    end
endmodule
